useq_ctrl: RTL and testbench
============================

USEQ_CTRL -- requirements
Module: useq_ctrl

Interface
REQ-001 Parameter AW, default 12: branch-address width (three cascaded 4-bit sequencer slices).
REQ-002 Parameter CW, default 8: loop-counter width.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 hold  input  1  stall; 1 freezes sequencing and all internal state.
REQ-006 cond  input  1  live test condition from datapath.
REQ-007 mw_op  input  3  microword next-address opcode, from control-store output.
REQ-008 mw_pol  input  1  condition polarity; 1 inverts cond.
REQ-009 mw_ba  input  AW  microword branch-address / count field.
REQ-010 s1, s0  output  1 each  sequencer source select: 00 PC, 01 AR, 10 stack, 11 din.
REQ-011 zero_n  output  1  0 forces sequencer address output to 0.
REQ-012 cin  output  1  1 increments the microprogram counter.
REQ-013 re_n  output  1  0 loads sequencer AR from din.
REQ-014 fe_n  output  1  0 enables a stack operation.
REQ-015 pup  output  1  with fe_n=0: 1 push, 0 pop.
REQ-016 din  output  AW  sequencer direct-data bus.
REQ-017 depth  output  3  tracked sequencer stack occupancy, 0..4.
REQ-018 ovf, unf  output  1 each  sticky stack overflow / underflow flags.

Function
REQ-019 Registers: ir_op(3), ir_pol(1), ir_ba(AW), cnt(CW), depth(3), ovf, unf, start(1).
REQ-020 Rising edge with hold=0 and start=0: ir_* load from mw_*.
REQ-021 start is set by reset and cleared on the first rising edge after reset_n deasserts.
REQ-022 Outputs are combinational from ir_*, cnt, start, hold, cond; ceff = cond XOR ir_pol.
REQ-023 din = ir_ba at all times except reset, when din = 0.
REQ-024 Defaults unless overridden: s=00, zero_n=1, cin=1, re_n=1, fe_n=1, pup=0.
REQ-025 Op 0 CONT: defaults.
REQ-026 Op 1 JUMP: s=11.
REQ-027 Op 2 CJP: s=11 if ceff=1, else defaults.
REQ-028 Op 3 CJS: if ceff=1: s=11, fe_n=0, pup=1; else defaults.
REQ-029 Op 4 CRTN: if ceff=1: s=10, fe_n=0, pup=0; else defaults.
REQ-030 Op 5 LDCT: defaults; on clock edge cnt <= ir_ba[CW-1:0].
REQ-031 Op 6 RPCT: if cnt!=0: s=11 and cnt <= cnt-1 on edge; if cnt=0: defaults, cnt stays 0.
REQ-032 Op 7 LDAR: defaults with re_n=0.
REQ-033 start=1 (first cycle after reset release): zero_n=0, cin=1, s=00, fe_n=1, re_n=1; hold ignored.
REQ-034 hold=1 (start=0): s=00, cin=0, zero_n=1, re_n=1, fe_n=1; ir, cnt, depth, flags unchanged.
REQ-035 Issued push (fe_n=0, pup=1) on edge: depth+1; at depth=4, depth stays 4 and ovf <= 1.
REQ-036 Issued pop (fe_n=0, pup=0) on edge: depth-1; at depth=0, depth stays 0 and unf <= 1.
REQ-037 Push/pop still driven to the sequencer at boundaries; sequencer stack wraps.
REQ-038 ovf and unf clear only on reset.
REQ-039 cnt arithmetic is modulo 2^CW; RPCT never decrements below 0.

Reset
REQ-040 While reset_n=0: ir_op=0, ir_pol=0, ir_ba=0, cnt=0, depth=0, ovf=0, unf=0, start=1.
REQ-041 While reset_n=0: zero_n=0, cin=0, s=00, fe_n=1, pup=0, re_n=1, din=0.
REQ-042 reset_n asserted mid-operation aborts the instruction immediately; no pending counter or stack update completes.

Verification
REQ-043 Release reset, hold=0 -> cycle 1: zero_n=0, cin=1; cycle 2: ir from mw_*, zero_n=1.
REQ-044 LDCT ba=3, then RPCT ba=0x040 x4 -> three cycles s=11, din=0x040, cnt 3->2->1->0; fourth cycle s=00, cin=1.
REQ-045 Five CJS with cond=1, pol=0 -> depth 1,2,3,4,4; ovf=1 after the fifth; fe_n=0, pup=1 each cycle.
REQ-046 CRTN cond=0, pol=1 at depth 0 -> s=10, fe_n=0, pup=0; depth stays 0; unf=1.
REQ-047 CJP cond=1 with hold=1 for 2 cycles -> s=00, cin=0, fe_n=1 both cycles; ir, depth, cnt unchanged; CJP executes on hold release.
REQ-048 reset_n low during RPCT with cnt=5 -> cnt=0, zero_n=0, din=0 asynchronously.

Source files
------------

// File: rtl/useq_ctrl.sv
// Next-address control for a cascaded 4-bit-slice microprogram sequencer:
// pipelines the microword, decodes the eight branch ops and tracks stack depth.
module useq_ctrl #(
  parameter int AW = 12,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hold,
  input  logic          cond,
  input  logic [2:0]    mw_op,
  input  logic          mw_pol,
  input  logic [AW-1:0] mw_ba,
  output logic          s1,
  output logic          s0,
  output logic          zero_n,
  output logic          cin,
  output logic          re_n,
  output logic          fe_n,
  output logic          pup,
  output logic [AW-1:0] din,
  output logic [2:0]    depth,
  output logic          ovf,
  output logic          unf
);

  typedef enum logic [2:0] {
    OP_CONT = 3'd0,
    OP_JUMP = 3'd1,
    OP_CJP  = 3'd2,
    OP_CJS  = 3'd3,
    OP_CRTN = 3'd4,
    OP_LDCT = 3'd5,
    OP_RPCT = 3'd6,
    OP_LDAR = 3'd7
  } op_e;

  localparam logic [2:0] DEPTH_MAX = 3'd4;

  op_e           ir_op_q,  ir_op_d;
  logic          ir_pol_q, ir_pol_d;
  logic [AW-1:0] ir_ba_q,  ir_ba_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    depth_q,  depth_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;
  logic          start_q,  start_d;

  logic [1:0]    sel;
  logic          ceff;
  logic          cnt_nz;

  assign ceff   = cond ^ ir_pol_q;
  assign cnt_nz = (cnt_q != '0);

  always_comb begin
    sel    = 2'b00;
    zero_n = 1'b1;
    cin    = 1'b1;
    re_n   = 1'b1;
    fe_n   = 1'b1;
    pup    = 1'b0;
    din    = ir_ba_q;
    if (!reset_n) begin
      zero_n = 1'b0;
      cin    = 1'b0;
      din    = '0;
    end else if (start_q) begin
      zero_n = 1'b0;
    end else if (hold) begin
      cin = 1'b0;
    end else begin
      case (ir_op_q)
        OP_JUMP: sel = 2'b11;
        OP_CJP:  if (ceff) sel = 2'b11;
        OP_CJS:  if (ceff) begin
                   sel  = 2'b11;
                   fe_n = 1'b0;
                   pup  = 1'b1;
                 end
        OP_CRTN: if (ceff) begin
                   sel  = 2'b10;
                   fe_n = 1'b0;
                 end
        OP_RPCT: if (cnt_nz) sel = 2'b11;
        OP_LDAR: re_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign s1    = sel[1];
  assign s0    = sel[0];
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  // Stack requests are always issued to the sequencer; only our depth
  // tracker saturates and records the boundary violation.
  always_comb begin
    ir_op_d  = ir_op_q;
    ir_pol_d = ir_pol_q;
    ir_ba_d  = ir_ba_q;
    cnt_d    = cnt_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    start_d  = 1'b0;
    if (!start_q && !hold) begin
      ir_op_d  = op_e'(mw_op);
      ir_pol_d = mw_pol;
      ir_ba_d  = mw_ba;
      if (ir_op_q == OP_LDCT) cnt_d = ir_ba_q[CW-1:0];
      if (ir_op_q == OP_RPCT && cnt_nz) cnt_d = cnt_q - 1'b1;
      if (!fe_n && pup) begin
        if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
        else                      depth_d = depth_q + 3'd1;
      end
      if (!fe_n && !pup) begin
        if (depth_q == 3'd0) unf_d = 1'b1;
        else                 depth_d = depth_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_op_q  <= OP_CONT;
      ir_pol_q <= 1'b0;
      ir_ba_q  <= '0;
      cnt_q    <= '0;
      depth_q  <= 3'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      start_q  <= 1'b1;
    end else begin
      ir_op_q  <= ir_op_d;
      ir_pol_q <= ir_pol_d;
      ir_ba_q  <= ir_ba_d;
      cnt_q    <= cnt_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      start_q  <= start_d;
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed bench for useq_ctrl: the driver queues hand-computed output
// vectors each cycle and an independent monitor pops and compares them.
module tb_useq_ctrl;

  localparam int AW = 12;
  localparam int CW = 8;

  logic          clock;
  logic          reset_n;
  logic          hold;
  logic          cond;
  logic [2:0]    mw_op;
  logic          mw_pol;
  logic [AW-1:0] mw_ba;
  logic          s1, s0, zero_n, cin, re_n, fe_n, pup;
  logic [AW-1:0] din;
  logic [2:0]    depth;
  logic          ovf, unf;

  useq_ctrl #(.AW(AW), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .cond(cond),
    .mw_op(mw_op), .mw_pol(mw_pol), .mw_ba(mw_ba),
    .s1(s1), .s0(s0), .zero_n(zero_n), .cin(cin), .re_n(re_n),
    .fe_n(fe_n), .pup(pup), .din(din), .depth(depth), .ovf(ovf), .unf(unf)
  );

  typedef struct {
    string       nm;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [2:0] CONT = 3'd0, JUMP = 3'd1, CJP = 3'd2, CJS = 3'd3,
                         CRTN = 3'd4, LDCT = 3'd5, RPCT = 3'd6, LDAR = 3'd7;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed order: s1 s0 zero_n cin re_n fe_n pup din depth ovf unf
  function automatic logic [23:0] mk(input logic [1:0] s, input logic zn, ci,
                                     rn, fn, pu, input logic [11:0] d,
                                     input logic [2:0] dp, input logic o, u);
    return {s, zn, ci, rn, fn, pu, d, dp, o, u};
  endfunction

  function automatic logic [23:0] dflt(input logic [11:0] d,
                                       input logic [2:0] dp, input logic o, u);
    return mk(2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, d, dp, o, u);
  endfunction

  task automatic step(input logic rn, h, c, input logic [2:0] op,
                      input logic p, input logic [11:0] ba,
                      input string nm, input logic [23:0] v);
    exp_t e;
    @(negedge clock);
    reset_n = rn;
    hold    = h;
    cond    = c;
    mw_op   = op;
    mw_pol  = p;
    mw_ba   = ba;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [23:0] act;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {s1, s0, zero_n, cin, re_n, fe_n, pup, din, depth, ovf, unf};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h (s1 s0 zn cin re fe pup din dep ovf unf)",
                   e.nm, act, e.v);
        end
      end
    end
  end

  initial begin : driver
    reset_n = 1'b0;
    hold    = 1'b0;
    cond    = 1'b0;
    mw_op   = JUMP;
    mw_pol  = 1'b0;
    mw_ba   = 12'h123;

    step(0, 0, 0, JUMP, 0, 12'h123, "reset",
         mk(2'b00, 0, 0, 1, 1, 0, 12'h000, 3'd0, 0, 0));
    step(1, 1, 0, JUMP, 0, 12'h123, "start",
         mk(2'b00, 0, 1, 1, 1, 0, 12'h000, 3'd0, 0, 0));
    step(1, 0, 0, LDCT, 0, 12'h003, "post_start", dflt(12'h000, 3'd0, 0, 0));
    step(1, 0, 0, RPCT, 0, 12'h040, "ldct3",      dflt(12'h003, 3'd0, 0, 0));
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, RPCT, 0, 12'h040, "rpct_run",
           mk(2'b11, 1, 1, 1, 1, 0, 12'h040, 3'd0, 0, 0));
    step(1, 0, 0, CJS, 0, 12'h100, "rpct_zero",  dflt(12'h040, 3'd0, 0, 0));
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, (i == 4) ? CRTN : CJS, (i == 4), (i == 4) ? 12'h2AA : 12'h100,
           "cjs_push", mk(2'b11, 1, 1, 1, 0, 1, 12'h100, 3'(i), 0, 0));
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, CRTN, 1, 12'h2AA, "crtn_pop",
           mk(2'b10, 1, 1, 1, 0, 0, 12'h2AA, 3'(4 - i), 1, 0));
    step(1, 0, 1, CJP,  0, 12'h3C5, "crtn_false", dflt(12'h2AA, 3'd0, 1, 1));
    step(1, 1, 1, JUMP, 0, 12'h777, "hold1",
         mk(2'b00, 1, 0, 1, 1, 0, 12'h3C5, 3'd0, 1, 1));
    step(1, 1, 1, LDAR, 0, 12'h055, "hold2",
         mk(2'b00, 1, 0, 1, 1, 0, 12'h3C5, 3'd0, 1, 1));
    step(1, 0, 1, LDAR, 0, 12'h055, "cjp_release",
         mk(2'b11, 1, 1, 1, 1, 0, 12'h3C5, 3'd0, 1, 1));
    step(1, 0, 0, CJP,  1, 12'h0F0, "ldar",
         mk(2'b00, 1, 1, 0, 1, 0, 12'h055, 3'd0, 1, 1));
    step(1, 0, 1, JUMP, 0, 12'h9AB, "cjp_pol_false", dflt(12'h0F0, 3'd0, 1, 1));
    step(1, 0, 0, LDCT, 0, 12'h005, "jump",
         mk(2'b11, 1, 1, 1, 1, 0, 12'h9AB, 3'd0, 1, 1));
    step(1, 0, 0, RPCT, 0, 12'h040, "ldct5",      dflt(12'h005, 3'd0, 1, 1));
    step(0, 0, 0, RPCT, 0, 12'h040, "reset_mid",
         mk(2'b00, 0, 0, 1, 1, 0, 12'h000, 3'd0, 0, 0));
    step(1, 0, 0, RPCT, 0, 12'h040, "restart",
         mk(2'b00, 0, 1, 1, 1, 0, 12'h000, 3'd0, 0, 0));
    step(1, 0, 0, RPCT, 0, 12'h040, "ir_cleared", dflt(12'h000, 3'd0, 0, 0));
    step(1, 0, 0, CONT, 0, 12'h000, "cnt_cleared", dflt(12'h040, 3'd0, 0, 0));
    step(1, 0, 0, CONT, 0, 12'h000, "cont",       dflt(12'h000, 3'd0, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clock);
      #3;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
